// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect/BTB/RAS inputs and PC/RAS status outputs of the fetch PC generator
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    logic            stall, flush_en, jump_en, btb_valid, btb_predict_taken, btb_is_ret, ras_push;
    logic [XLEN-1:0] flush_pc, jump_addr, btb_target, ras_push_addr;
    logic [XLEN-1:0] pc, next_pc;
    logic [CW-1:0]   ras_count;
    logic            ras_empty;
    modport master (
        output stall, flush_en, flush_pc, jump_en, jump_addr, btb_valid, btb_predict_taken,
               btb_target, btb_is_ret, ras_push, ras_push_addr,
        input  pc, next_pc, ras_count, ras_empty
    );
    modport slave (
        input  stall, flush_en, flush_pc, jump_en, jump_addr, btb_valid, btb_predict_taken,
               btb_target, btb_is_ret, ras_push, ras_push_addr,
        output pc, next_pc, ras_count, ras_empty
    );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC generator with flush/jump/RAS/BTB redirect priority and a circular return-address stack
module pc_gen_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    logic [XLEN-1:0] pc_q, pc_d, npc;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d, wr_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            empty, ret_sel, adv, pop, push;
    always_comb begin
        empty   = cnt_q == '0;
        ret_sel = bus.btb_valid & bus.btb_is_ret & ~empty;
        npc     = bus.flush_en ? bus.flush_pc :
                  bus.jump_en  ? bus.jump_addr :
                  ret_sel      ? ras_q[top_q] :
                  (bus.btb_valid & bus.btb_predict_taken) ? bus.btb_target : pc_q + XLEN'(4);
        adv     = ~bus.stall | bus.flush_en;
        pop     = ret_sel & ~bus.flush_en & ~bus.jump_en & adv;
        push    = bus.ras_push & ~bus.flush_en & ~bus.stall;
        pc_d    = adv ? npc : pc_q;
        top_d   = (push & ~pop) ? top_q + PW'(1) : (pop & ~push) ? top_q - PW'(1) : top_q;
        cnt_d   = (push & ~pop) ? ((cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1)) :
                  (pop & ~push) ? cnt_q - CW'(1) : cnt_q;
        // A push paired with a pop replaces the entry being returned through
        wr_idx  = pop ? top_q : top_q + PW'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) ras_q[wr_idx] <= bus.ras_push_addr;
    end
    assign bus.pc        = pc_q;
    assign bus.next_pc   = npc;
    assign bus.ras_count = cnt_q;
    assign bus.ras_empty = empty;
endmodule
